// File: rtl/arbiter_grant_mux.sv
// Consumes a one-hot grant from the IWRR arbiter, pops the granted requester and
// buffers {src, data} in a 2-entry FIFO presented as a valid/ready stream.
module arbiter_grant_mux #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_DATA_W        = 32,
  parameter int P_SRC_W         = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [P_REQUESTER_NUM-1:0]           req_valid_i,
  input  logic [P_REQUESTER_NUM*P_DATA_W-1:0]  req_data_i,
  output logic [P_REQUESTER_NUM-1:0]           req_ready_o,
  input  logic [P_REQUESTER_NUM-1:0]           grant_valid_i,
  output logic                                 grant_ready_o,
  output logic                                 m_valid_o,
  output logic [P_DATA_W-1:0]                  m_data_o,
  output logic [P_SRC_W-1:0]                   m_src_o,
  input  logic                                 m_ready_i,
  output logic                                 err_o
);

  logic [1:0]          r_count;
  logic                r_wptr;
  logic                r_rptr;
  logic                r_err;
  logic [P_DATA_W-1:0] r_data [2];
  logic [P_SRC_W-1:0]  r_src  [2];

  logic [P_SRC_W-1:0]  w_sel;
  logic [P_DATA_W-1:0] w_sel_data;
  logic                w_any;
  logic                w_multi_hot;
  logic                w_sel_valid;
  logic                w_push;
  logic                w_pop;
  logic                w_err_evt;

  // Downward scan so the lowest set grant bit wins the final assignment.
  always_comb begin
    w_sel      = '0;
    w_sel_data = '0;
    for (int unsigned i = P_REQUESTER_NUM; i > 0; i--) begin
      if (grant_valid_i[i-1]) begin
        w_sel      = P_SRC_W'(i - 1);
        w_sel_data = req_data_i[(i-1)*P_DATA_W +: P_DATA_W];
      end
    end
  end

  assign w_any       = |grant_valid_i;
  assign w_multi_hot = |(grant_valid_i & (grant_valid_i - P_REQUESTER_NUM'(1)));
  assign w_sel_valid = |(grant_valid_i & req_valid_i);

  assign grant_ready_o = ~rst & (r_count != 2'd2);
  assign w_push        = grant_ready_o & w_any & w_sel_valid & ~w_multi_hot;
  assign w_err_evt     = grant_ready_o & w_any & (w_multi_hot | ~w_sel_valid);
  assign w_pop         = m_valid_o & m_ready_i;

  // A legal push implies a one-hot grant, so the grant vector is the pop strobe.
  assign req_ready_o = w_push ? grant_valid_i : '0;

  assign m_valid_o = (r_count != 2'd0);
  assign m_data_o  = r_data[r_rptr];
  assign m_src_o   = r_src[r_rptr];
  assign err_o     = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_src[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= w_sel_data;
        r_src[r_wptr]  <= w_sel;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_err <= r_err | w_err_evt;
    end
  end

endmodule

// File: doc/arbiter_grant_mux.md
Name: arbiter_grant_mux

Overview:
- Downstream consumer of the IWRR arbiter's one-hot grant vector.
- Selects the granted requester's data beat, pops that requester, and pushes the beat plus its source index into a 2-entry output buffer.
- Drives the grant ready handshake back to the arbiter and presents a valid/ready stream to the next stage.

Parameters:
P_REQUESTER_NUM, 3, number of requesters; must match the arbiter.
P_DATA_W, 32, data width per requester.
P_SRC_W, $clog2(P_REQUESTER_NUM) (minimum 1), width of the source index.

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
req_valid_i  input  P_REQUESTER_NUM  per-requester data-available flag; the same vector drives the arbiter req_i
req_data_i  input  P_REQUESTER_NUM*P_DATA_W  requester i data in bits [i*P_DATA_W +: P_DATA_W]
req_ready_o  output  P_REQUESTER_NUM  pop strobe to requester i
grant_valid_i  input  P_REQUESTER_NUM  one-hot grant from the arbiter
grant_ready_o  output  1  to arbiter grant_ready_i; the grant is consumed when high
m_valid_o  output  1  output beat valid
m_data_o  output  P_DATA_W  output beat data
m_src_o  output  P_SRC_W  index of the requester that produced the beat
m_ready_i  input  1  downstream accept
err_o  output  1  sticky protocol-error flag

Behaviour:
- Storage: 2-entry FIFO of {src, data}, with registered count in 0..2, write pointer and read pointer.
- Outputs are driven from the head entry. m_valid_o = (count != 0).
- grant_ready_o = ~rst & (count != 2). It is derived from registered state only, with no combinational path from m_ready_i.
- push = grant_ready_o & |grant_valid_i & req_valid_i[sel] & ~multi_hot.
  - sel is the lowest set bit of grant_valid_i.
  - multi_hot means more than one bit of grant_valid_i is set.
- req_ready_o[i] = push & (sel == i). At most one bit is high per cycle.
- pop = m_valid_o & m_ready_i.
- Latency: a beat pushed in cycle N appears on m_valid_o/m_data_o in cycle N+1.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, and both pointers advance.
  - push and pop together is legal at count 1. At count 2 no push occurs; a pop at count 2 frees a slot, so grant_ready_o is 1 in the next cycle.
- Sustained throughput is 1 beat/cycle when m_ready_i is held high.
- Data is stable: m_data_o and m_src_o must not change while m_valid_o=1 and m_ready_i=0.
- Protocol errors: err_o is set the cycle after either condition below and stays set until rst.
  - grant_valid_i is multi-hot while grant_ready_o=1: no push, no req_ready_o.
  - The granted requester has req_valid_i=0 while grant_ready_o=1: no push.
- When grant_valid_i=0, nothing happens and grant_ready_o still reflects FIFO space. The arbiter may hold or re-evaluate its grant.
- Reset: takes effect on the clock edge while rst=1 and overrides any push/pop in that cycle.
  - count=0, pointers=0, m_valid_o=0, m_data_o=0, m_src_o=0, err_o=0.
  - grant_ready_o=0 and req_ready_o=0 combinationally while rst=1.
  - Mid-operation reset discards buffered beats; nothing is popped from requesters.
- Pointer wrap-around: 1-bit pointers toggle 1→0.

Test Plan:
- Reset, then grant=3'b010, req_valid=3'b111, data1=32'hA5A5_0001, m_ready=1 → cycle+1: m_valid=1, m_data=A5A5_0001, m_src=1; req_ready=3'b010 pulsed in the grant cycle only.
- m_ready=0, grants 001 then 100 on consecutive cycles → count=2, grant_ready_o=0 in the 3rd cycle; head holds src 0 stable. Then m_ready=1 for one cycle → src 0 popped, grant_ready_o=1 the next cycle, then src 2 delivered.
- m_ready=1, grants cycling 001→010→100 for 9 cycles → 9 beats, in order, one per cycle; count never exceeds 1.
- grant=3'b011 → no push, req_ready=0, err_o=1 the next cycle and stays 1 through later legal traffic until rst.
- grant=3'b100 with req_valid=3'b011 → no push, err_o=1.
- 2 beats buffered, m_ready=0, rst pulsed 1 cycle → m_valid=0, m_data=0, m_src=0, err_o=0, grant_ready_o=0 during rst and 1 afterwards; no beats appear after reset.
